// File: rtl/config_net_tx_if.sv
// Parallel packet handshake between a config-net host and config_net_tx.
interface config_net_tx_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic                 valid_i;
  logic                 ready_o;
  logic [7:0]           id_i;
  logic [DATA_BITS-1:0] data_i;

  modport master (output valid_i, output id_i, output data_i, input ready_o);
  modport slave  (input valid_i, input id_i, input data_i, output ready_o);
endinterface

// File: rtl/config_net_tx.sv
// Config-net serial transmitter: accepts {id, data} on a valid/ready handshake
// and emits the framed LSB-first packet on cfg_bit_o, clocked by a free-running
// divided cfg_clk_o. cfg_bit_o only changes when cfg_clk_o falls.
module config_net_tx #(
  parameter int unsigned data_bits_p   = 32,
  parameter int unsigned half_period_p = 2,
  parameter int unsigned idle_bits_p   = 2
) (
  input  logic           clk,
  input  logic           reset,
  config_net_tx_if.slave host,
  output logic           cfg_clk_o,
  output logic           cfg_bit_o
);

  localparam int unsigned NBytes = data_bits_p / 8;
  localparam int unsigned ShiftW = data_bits_p + 16;
  localparam int unsigned ByteW  = $clog2(NBytes + 2);
  localparam int unsigned GapW   = $clog2(idle_bits_p + 1);
  localparam int unsigned HpW    = (half_period_p > 1) ? $clog2(half_period_p) : 1;

  localparam logic [ByteW-1:0] LastByte = ByteW'(NBytes + 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(idle_bits_p - 1);
  localparam logic [HpW-1:0]   HpLast   = HpW'(half_period_p - 1);
  localparam logic [7:0]       LenByte  = 8'(NBytes);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_FRAME,
    S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [HpW-1:0]      hp_cnt_q, hp_cnt_d;
  logic                clk_q, clk_d;
  logic                bit_q, bit_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;

  logic toggle;
  logic boundary;
  logic hs;

  // A bit boundary is the clk edge on which cfg_clk falls.
  assign toggle   = (hp_cnt_q == HpLast);
  assign boundary = toggle & clk_q;
  assign hs       = host.valid_i & (state_q == S_IDLE);

  assign host.ready_o = (state_q == S_IDLE);
  assign cfg_clk_o    = clk_q;
  assign cfg_bit_o    = bit_q;

  // State and datapath registers; reset returns the line to idle levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_GAP;
      hp_cnt_q   <= '0;
      clk_q      <= 1'b0;
      bit_q      <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      clk_q      <= clk_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Clock divider, next-state and serial bit selection.
  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = toggle ? '0 : hp_cnt_q + 1'b1;
    clk_d      = toggle ? ~clk_q : clk_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          shift_d = {host.data_i, host.id_i, LenByte};
          state_d = S_START;
        end
      end

      S_START: begin
        if (boundary) begin
          bit_d      = 1'b0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = S_BYTE;
        end
      end

      S_BYTE: begin
        if (boundary) begin
          bit_d   = shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_FRAME;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      S_FRAME: begin
        if (boundary) begin
          bit_d     = 1'b0;
          bit_cnt_d = '0;
          if (byte_cnt_q == LastByte) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = S_BYTE;
          end
        end
      end

      S_GAP: begin
        if (boundary) begin
          bit_d = 1'b1;
          if (gap_cnt_q == GapLast) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_GAP;
    endcase
  end

endmodule
